// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI word loader: FSM states, SPI mode codes, per-field SCK counts.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package spi_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DATA,
    STALL,
    HOLD
  } state_e;

  localparam logic [1:0] SPI_STD     = 2'b00;
  localparam logic [1:0] SPI_QUAD_TX = 2'b01;

  // SCK periods needed to shift one field, single-bit vs nibble lanes
  localparam int unsigned CMD_SCK_STD   = 8;
  localparam int unsigned ADDR_SCK_STD  = 32;
  localparam int unsigned WORD_SCK_STD  = 32;
  localparam int unsigned CMD_SCK_QUAD  = 2;
  localparam int unsigned ADDR_SCK_QUAD = 8;
  localparam int unsigned WORD_SCK_QUAD = 8;

  // Width of the per-field SCK counter (holds up to 32)
  localparam int unsigned BITS_W = 6;

  function automatic logic [BITS_W-1:0] field_sck(input logic quad,
                                                  input int unsigned n_std,
                                                  input int unsigned n_quad);
    return quad ? BITS_W'(n_quad) : BITS_W'(n_std);
  endfunction

  // Zero-length bursts send one word; over-long bursts are cut to max_len
  function automatic logic [8:0] clamp_len(input logic [8:0] len, input int unsigned max_len);
    if (len == 9'd0) return 9'd1;
    if (32'(len) > max_len) return 9'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/spi_loader_clkgen.sv
// SCK generator: half-period tick every CLK_DIV s_clk cycles, SCK level plus rise/fall strobes.
// Latency: first rise strobe CLK_DIV cycles after en_i goes high; SCK idles low.
// Backpressure: none; dropping en_i parks SCK low and restarts the divider from zero.
module spi_loader_clkgen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic s_clk,
  input  logic s_rst_n,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;
  logic       tick;

  assign tick = en_i && (cnt_q == DIV_LAST);

  // Divider counter and SCK level; disabled means parked low with a fresh count
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider state registers
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = tick && !sck_q;
  assign fall_o = tick && sck_q;

endmodule

// File: rtl/spi_word_loader.sv
// SPI master burst writer: WR_CMD, 32-bit address, then N 32-bit words, mode 0, MSB first (quad lanes with SPI_LOADER_QUAD_EN).
// Latency: CSN falls the cycle after req accept; done_o pulses 2*CLK_DIV cycles after the last SCK fall.
// Backpressure: req_ready only in IDLE; a missing word at a boundary parks SCK low with CSN held low until data_valid.
module spi_word_loader
  import spi_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [7:0]  WR_CMD  = 8'h02,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        s_clk,
  input  logic        s_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [8:0]  req_len,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data_word,
  input  logic        quad_i,
  output logic        spi_sck_o,
  output logic        spi_csn_o,
  output logic [1:0]  spi_mode_o,
  output logic [3:0]  spi_sdo_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [8:0]          wcnt_q, wcnt_d;
  logic [BITS_W-1:0]   bits_q, bits_d;
  logic [31:0]         sh_q, sh_d;
  logic [8:0]          hold_q, hold_d;
  logic                rdy_q, rdy_d;
  logic                done_q, done_d;

  logic                sck, sck_rise, sck_fall;
  logic                clk_en, frame;
  logic                boundary;
  logic                quad_acc, quad_cur;
  logic [31:0]         sh_shift;
  logic [3:0]          sdo_raw;

`ifdef SPI_LOADER_QUAD_EN
  logic quad_q, quad_d;
  assign quad_acc = quad_i;
  assign quad_cur = quad_q;
  assign sh_shift = quad_q ? {sh_q[27:0], 4'h0} : {sh_q[30:0], 1'b0};
  assign sdo_raw  = quad_q ? sh_q[31:28] : {3'b000, sh_q[31]};
`else
  logic unused_quad;
  assign unused_quad = quad_i;
  assign quad_acc = 1'b0;
  assign quad_cur = 1'b0;
  assign sh_shift = {sh_q[30:0], 1'b0};
  assign sdo_raw  = {3'b000, sh_q[31]};
`endif

  assign frame  = state_q inside {SETUP, CMD, ADDR, DATA, STALL};
  assign clk_en = state_q inside {SETUP, CMD, ADDR, DATA};

  spi_loader_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .s_clk   (s_clk),
    .s_rst_n (s_rst_n),
    .en_i    (clk_en),
    .sck_o   (sck),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // Frame sequencing: field shifting on SCK falls, word loads at boundaries, CSN hold, done pulse
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    bits_d     = bits_q;
    sh_d       = sh_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    data_ready = 1'b0;
    boundary   = 1'b0;
`ifdef SPI_LOADER_QUAD_EN
    quad_d     = quad_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          addr_d  = req_addr;
          wcnt_d  = clamp_len(req_len, MAX_LEN);
`ifdef SPI_LOADER_QUAD_EN
          quad_d  = quad_i;
`endif
          sh_d    = {WR_CMD, 24'h0};
          bits_d  = field_sck(quad_acc, CMD_SCK_STD, CMD_SCK_QUAD);
          state_d = SETUP;
        end
      end
      // First command bit is already on sdo; wait out one low half-period
      SETUP: begin
        if (sck_rise) state_d = CMD;
      end
      CMD: begin
        if (sck_fall) begin
          if (bits_q != BITS_W'(1)) begin
            sh_d   = sh_shift;
            bits_d = bits_q - BITS_W'(1);
          end else begin
            sh_d    = addr_q;
            bits_d  = field_sck(quad_cur, ADDR_SCK_STD, ADDR_SCK_QUAD);
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (sck_fall) begin
          if (bits_q != BITS_W'(1)) begin
            sh_d   = sh_shift;
            bits_d = bits_q - BITS_W'(1);
          end else begin
            boundary = 1'b1;
          end
        end
      end
      DATA: begin
        if (sck_fall) begin
          if (bits_q != BITS_W'(1)) begin
            sh_d   = sh_shift;
            bits_d = bits_q - BITS_W'(1);
          end else if (wcnt_q == 9'd0) begin
            hold_d  = '0;
            state_d = HOLD;
          end else begin
            boundary = 1'b1;
          end
        end
      end
      STALL: begin
        boundary = 1'b1;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Word boundary: take the next word if offered, otherwise park with SCK low
    if (boundary) begin
      if (data_valid) begin
        sh_d       = data_word;
        bits_d     = field_sck(quad_cur, WORD_SCK_STD, WORD_SCK_QUAD);
        wcnt_d     = wcnt_q - 9'd1;
        data_ready = 1'b1;
        state_d    = DATA;
      end else begin
        state_d = STALL;
      end
    end

    rdy_d = (state_d == IDLE);
  end

  // Loader state registers; reset aborts any frame in flight
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_LOADER_QUAD_EN
  // Lane mode captured at request accept
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) quad_q <= 1'b0;
    else          quad_q <= quad_d;
  end
`endif

  assign req_ready  = rdy_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign spi_sck_o  = sck;
  assign spi_csn_o  = ~frame;
  assign spi_sdo_o  = frame ? sdo_raw : 4'h0;
  assign spi_mode_o = (frame && quad_cur) ? SPI_QUAD_TX : SPI_STD;

endmodule

// File: doc/spi_word_loader.md
SPI_WORD_LOADER -- requirements
Module: spi_word_loader

Interface
REQ-001 Parameter CLK_DIV, default 2: s_clk cycles per SCK half-period; legal range 1..255.
REQ-002 Parameter WR_CMD, default 8'h02: SPI-slave memory-write command byte.
REQ-003 Parameter MAX_LEN, default 256: maximum number of words per burst.
REQ-004 Ports, in this order: s_clk in 1 clock; s_rst_n in 1 asynchronous active-low reset.
REQ-005 Request ports: req_valid in 1; req_ready out 1; req_addr in 32 (burst base address); req_len in 9 (word count, 1..MAX_LEN).
REQ-006 Data ports: data_valid in 1; data_ready out 1; data_word in 32.
REQ-007 Mode port: quad_i in 1, selects 4-bit transfer when set; sampled at request accept.
REQ-008 SPI ports: spi_sck_o out 1; spi_csn_o out 1; spi_mode_o out 2 (00 single, 01 quad TX); spi_sdo_o out 4.
REQ-009 Status ports: busy_o out 1; done_o out 1, a one-cycle pulse.

Function
REQ-010 SPI mode SHALL be CPOL=0, CPHA=0; sdo SHALL change only on SCK falling edges or while CSN is high.
REQ-011 Frame SHALL be WR_CMD byte, then req_addr, then req_len words; every field SHALL be sent MSB first.
REQ-012 Single mode SHALL send 1 bit per SCK on sdo[0], with sdo[3:1]=0: cmd 8, addr 32, word 32 SCKs.
REQ-013 Quad mode SHALL send 1 nibble per SCK on sdo[3:0]: cmd 2, addr 8, word 8 SCKs.
REQ-014 FSM states SHALL be IDLE, SETUP, CMD, ADDR, DATA, STALL, HOLD; after reset the state SHALL be IDLE.
REQ-015 IDLE: req_ready=1; on req_valid&&req_ready, latch addr, len and mode, then go to SETUP.
REQ-016 SETUP: CSN low with first cmd bit driven; after CLK_DIV cycles go to CMD.
REQ-017 CMD and ADDR phases SHALL each shift out their field, then advance to the next phase.
REQ-018 DATA: data_ready SHALL pulse one cycle when a word is loaded into the shifter, and SHALL be asserted only when a word boundary is reached and data_valid=1.
REQ-019 At a word boundary with data_valid=0, go to STALL: SCK held low, CSN held low, no timeout; resume the cycle after data_valid=1.
REQ-020 After the last SCK fall of the last word, go to HOLD: CSN high, SCK low, sdo=0 for 2*CLK_DIV cycles.
REQ-021 Leaving HOLD, done_o SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-022 busy_o SHALL be 1 in every state except IDLE.
REQ-023 req_len=0 SHALL be treated as 1; req_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-024 A req_valid asserted while busy SHALL be ignored (req_ready=0) and SHALL be accepted in the first IDLE cycle.
REQ-025 The word counter SHALL decrement per word; the burst SHALL end at count 0, with no address wrap checks.
REQ-026 spi_mode_o SHALL equal 01 from SETUP through DATA when quad is latched, and 00 otherwise.

Reset
REQ-027 Asynchronous assert of s_rst_n low SHALL force IDLE, spi_csn_o=1, spi_sck_o=0, spi_sdo_o=0, spi_mode_o=00.
REQ-028 The same reset SHALL force req_ready=0 while in reset, data_ready=0, busy_o=0, done_o=0, and all counters to 0.
REQ-029 A reset asserted mid-frame SHALL abort the frame immediately, with no done_o pulse.
REQ-030 After reset release, req_ready SHALL rise on the first s_clk edge.

Configuration
REQ-031 Macro SPI_LOADER_QUAD_EN SHALL enable quad support.
REQ-032 With SPI_LOADER_QUAD_EN defined, behaviour SHALL be as specified in REQ-007 to REQ-026.
REQ-033 With SPI_LOADER_QUAD_EN undefined, quad_i SHALL be ignored: single mode only, spi_mode_o=00, sdo[3:1]=0, and no nibble-shift logic.

Structure
REQ-034 Shared package spi_loader_pkg SHALL hold the FSM state enum, the SPI_STD and SPI_QUAD_TX mode constants, and the phase bit-count constants.
REQ-035 Sub-module spi_loader_clkgen SHALL generate the SCK half-period tick and rise/fall strobes from CLK_DIV, gated by an enable.

Verification
REQ-036 Single, CLK_DIV=2, addr 0x0000_1000, len 1, word 0xDEADBEEF -> 72 SCKs; sampled bits 0x02, 0x00001000, 0xDEADBEEF; one done_o pulse.
REQ-037 Quad, addr 0x0010_0000, len 2, words 0x12345678 and 0x9ABCDEF0 -> 26 SCKs; nibbles in order; spi_mode_o=01.
REQ-038 Quad, data_valid dropped 50 cycles before word 2 -> SCK low and CSN low throughout the gap; frame bits identical to REQ-037.
REQ-039 Reset pulsed at SCK 40 of a single-mode frame -> CSN=1 immediately; no done_o; next request completes normally.
REQ-040 req_len=0 -> exactly one word sent; req_valid held during the frame -> second frame starts only after done_o.
REQ-041 Build without SPI_LOADER_QUAD_EN, quad_i=1 -> 72-SCK single frame, sdo[3:1]=0 throughout.
